// File: rtl/add_pkg.sv
// Shared types and widths for the multi-word addition sequencer and its 32-bit adder.
package add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Word index width; a single-word operand still needs a 1-bit index.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add32_cla.sv
// Registered 32-bit adder with 4-bit carry-lookahead groups; result lands one cycle after enable.
// Outputs hold while enable is low; no backpressure (the caller paces it via enable).
module add32_cla
  import add_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum_r,
  output logic              cout_r
);

  localparam int GROUPS = WORD_W / 4;

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS:0]   grp_c;
  logic [WORD_W-1:0] sum_c;
  logic              cout_c;
  logic              carry;

  always_comb begin
    g      = a & b;
    p      = a ^ b;
    grp_g  = '0;
    grp_p  = '0;
    grp_c  = '0;
    sum_c  = '0;
    carry  = 1'b0;
    grp_c[0] = cin;
    // Group generate/propagate give each nibble its carry-in without waiting on lower bits.
    for (int k = 0; k < GROUPS; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < GROUPS; k++) begin
      carry = grp_c[k];
      for (int j = 0; j < 4; j++) begin
        sum_c[4*k+j] = p[4*k+j] ^ carry;
        carry        = g[4*k+j] | (p[4*k+j] & carry);
      end
    end
    cout_c = grp_c[GROUPS];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (enable) begin
      sum_r  <= sum_c;
      cout_r <= cout_c;
    end
  end

endmodule

// File: rtl/addn_seq.sv
// Sequences a WORDS x 32-bit add through add32_cla, LSW first; result valid WORDS+1 cycles after accept.
// One operation in flight; in_ready low while busy, result and carry held stable until out_ready.
module addn_seq
  import add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] in_a,
  input  logic [WORD_W*WORDS-1:0] in_b,
  input  logic                    in_cin,
  output logic                    add_enable,
  output logic [WORD_W-1:0]       add_a,
  output logic [WORD_W-1:0]       add_b,
  output logic                    add_cin,
  input  logic [WORD_W-1:0]       add_sum,
  input  logic                    add_cout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] out_sum,
  output logic                    out_cout
);

  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  seq_state_t                     state;
  seq_state_t                     state_nxt;
  logic [IDX_W-1:0]               idx;
  logic [WORDS-1:0][WORD_W-1:0]   a_lat;
  logic [WORDS-1:0][WORD_W-1:0]   b_lat;
  logic                           cin_lat;
  logic [WORDS-1:0][WORD_W-1:0]   sum_q;
  logic                           cout_q;

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_enable = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_enable = 1'b1;
        add_a      = a_lat[idx];
        add_b      = b_lat[idx];
        // The adder's registered carry already belongs to the previous word.
        add_cin    = (idx == '0) ? cin_lat : add_cout;
        if (idx == LAST) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      cin_lat <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_lat   <= in_a;
            b_lat   <= in_b;
            cin_lat <= in_cin;
            idx     <= '0;
          end
        end
        RUN: begin
          if (idx != '0) sum_q[idx - 1'b1] <= add_sum;
          if (idx != LAST) idx <= idx + 1'b1;
        end
        FLUSH: begin
          sum_q[LAST] <= add_sum;
          cout_q      <= add_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addn_seq.sv
// Bench for addn_seq with add32_cla at WORDS=4 and WORDS=1, checked against a wide-add scoreboard.
module tb_addn_seq;
  import add_pkg::*;

  typedef struct packed {
    logic [127:0] sum;
    logic         cout;
  } exp4_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid4 = 1'b0, in_ready4, in_cin4 = 1'b0;
  logic [127:0] in_a4 = '0, in_b4 = '0;
  logic         add_enable4, add_cin4, add_cout4;
  logic [31:0]  add_a4, add_b4, add_sum4;
  logic         out_valid4, out_ready4 = 1'b0, out_cout4;
  logic [127:0] out_sum4;

  logic         in_valid1 = 1'b0, in_ready1, in_cin1 = 1'b0;
  logic [31:0]  in_a1 = '0, in_b1 = '0;
  logic         add_enable1, add_cin1, add_cout1;
  logic [31:0]  add_a1, add_b1, add_sum1;
  logic         out_valid1, out_ready1 = 1'b1, out_cout1;
  logic [31:0]  out_sum1;

  exp4_t       q4[$];
  logic [32:0] q1[$];
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] ONES = {128{1'b1}};

  addn_seq #(.WORDS(4)) u_seq4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
    .add_enable(add_enable4), .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .add_cout(add_cout4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4), .out_cout(out_cout4)
  );
  add32_cla u_add4 (
    .clk(clk), .rst(rst), .enable(add_enable4), .a(add_a4), .b(add_b4), .cin(add_cin4),
    .sum_r(add_sum4), .cout_r(add_cout4)
  );

  addn_seq #(.WORDS(1)) u_seq1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .add_enable(add_enable1), .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1)
  );
  add32_cla u_add1 (
    .clk(clk), .rst(rst), .enable(add_enable1), .a(add_a1), .b(add_b1), .cin(add_cin1),
    .sum_r(add_sum1), .cout_r(add_cout1)
  );

  function automatic exp4_t model4(input logic [127:0] a, input logic [127:0] b, input logic c);
    logic [128:0] t;
    t = {1'b0, a} + {1'b0, b} + {128'd0, c};
    return '{sum: t[127:0], cout: t[128]};
  endfunction

  // Drives one operand pair from a negedge; returns at the negedge after the accepting edge.
  task automatic send4(input logic [127:0] a, input logic [127:0] b, input logic c);
    int n = 0;
    in_valid4 = 1'b1; in_a4 = a; in_b4 = b; in_cin4 = c;
    while (!in_ready4 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready4) begin errors++; $display("FAIL send4_accept: in_ready stayed 0 for %0d cycles", n); end
    q4.push_back(model4(a, b, c));
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic test_reset_state;
    checks += 4;
    if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid4); end
    if (add_enable4 !== 1'b0) begin errors++; $display("FAIL rst_add_enable: got %b want 0", add_enable4); end
    if (out_sum4 !== 128'd0) begin errors++; $display("FAIL rst_out_sum: got %h want 0", out_sum4); end
    if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_out_valid1: got %b want 0", out_valid1); end
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (in_ready4 !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready4); end
    if (in_ready1 !== 1'b1) begin errors++; $display("FAIL rst_in_ready1: got %b want 1", in_ready1); end
  endtask

  task automatic test_simple;
    int en_cnt = 0;
    exp4_t e;
    out_ready4 = 1'b1;
    send4(128'h1, 128'h1, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      if (add_enable4) en_cnt++;
      checks++;
      if (out_valid4 !== (i == 5)) begin
        errors++; $display("FAIL simple_out_valid_c%0d: got %b want %b", i, out_valid4, (i == 5));
      end
      if (i < 5) @(negedge clk);
    end
    checks++;
    if (en_cnt != 4) begin errors++; $display("FAIL simple_enable_cycles: got %0d want 4", en_cnt); end
    e = q4.pop_front();
    checks += 2;
    if (out_sum4 !== 128'h2) begin errors++; $display("FAIL simple_sum: got %h want %h", out_sum4, 128'h2); end
    if (out_cout4 !== e.cout) begin errors++; $display("FAIL simple_cout: got %b want %b", out_cout4, e.cout); end
    @(negedge clk);
  endtask

  task automatic test_ripple;
    int n = 0;
    exp4_t e;
    out_ready4 = 1'b1;
    send4(ONES, 128'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        checks++;
        if (add_cin4 !== 1'b1) begin errors++; $display("FAIL ripple_add_cin_w%0d: got %b want 1", i, add_cin4); end
      end
      @(negedge clk);
    end
    while (!out_valid4 && n < 50) begin @(negedge clk); n++; end
    e = q4.pop_front();
    checks += 3;
    if (!out_valid4) begin errors++; $display("FAIL ripple_timeout: out_valid never rose"); end
    if (out_sum4 !== 128'd0 || e.sum !== 128'd0) begin errors++; $display("FAIL ripple_sum: got %h want 0", out_sum4); end
    if (out_cout4 !== 1'b1) begin errors++; $display("FAIL ripple_cout: got %b want 1", out_cout4); end
    @(negedge clk);
  endtask

  task automatic test_max;
    int n = 0;
    exp4_t e;
    out_ready4 = 1'b1;
    send4(ONES, ONES, 1'b1);
    while (!out_valid4 && n < 50) begin @(negedge clk); n++; end
    e = q4.pop_front();
    checks += 3;
    if (!out_valid4) begin errors++; $display("FAIL max_timeout: out_valid never rose"); end
    if (out_sum4 !== ONES) begin errors++; $display("FAIL max_sum: got %h want %h", out_sum4, ONES); end
    if (out_cout4 !== 1'b1 || e.cout !== 1'b1) begin errors++; $display("FAIL max_cout: got %b want 1", out_cout4); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    send4(128'h7, 128'h5, 1'b0);
    q4.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (out_valid4 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid4); end
    if (add_enable4 !== 1'b0) begin errors++; $display("FAIL midrst_add_enable: got %b want 0", add_enable4); end
    if (out_sum4 !== 128'd0) begin errors++; $display("FAIL midrst_out_sum: got %h want 0", out_sum4); end
    if (out_cout4 !== 1'b0) begin errors++; $display("FAIL midrst_out_cout: got %b want 0", out_cout4); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready4 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready4); end
  endtask

  task automatic test_backpressure;
    int n = 0;
    exp4_t e;
    logic [127:0] a2 = 128'h0123_4567_89AB_CDEF_FFFF_FFFF_0000_0001;
    logic [127:0] b2 = 128'h1111_1111_2222_2222_0000_0001_FFFF_FFFF;
    out_ready4 = 1'b0;
    send4(128'hDEAD_BEEF_0000_0000_FFFF_FFFF_1234_5678, 128'h1, 1'b1);
    while (!out_valid4 && n < 50) begin @(negedge clk); n++; end
    in_valid4 = 1'b1; in_a4 = a2; in_b4 = b2; in_cin4 = 1'b0;
    e = q4[0];
    for (int i = 0; i < 10; i++) begin
      checks += 4;
      if (out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_out_valid_c%0d: got %b want 1", i, out_valid4); end
      if (out_sum4 !== e.sum || out_cout4 !== e.cout) begin
        errors++; $display("FAIL bp_sum_c%0d: got %b_%h want %b_%h", i, out_cout4, out_sum4, e.cout, e.sum);
      end
      if (in_ready4 !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b want 0", i, in_ready4); end
      if (add_enable4 !== 1'b0) begin errors++; $display("FAIL bp_add_enable_c%0d: got %b want 0", i, add_enable4); end
      @(negedge clk);
    end
    out_ready4 = 1'b1;
    void'(q4.pop_front());
    @(negedge clk);
    checks++;
    if (in_ready4 !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready4); end
    q4.push_back(model4(a2, b2, 1'b0));
    @(negedge clk);
    in_valid4 = 1'b0;
    checks++;
    if (in_ready4 !== 1'b0) begin errors++; $display("FAIL bp_new_accept: in_ready got %b want 0", in_ready4); end
    n = 0;
    while (!out_valid4 && n < 50) begin @(negedge clk); n++; end
    e = q4.pop_front();
    checks++;
    if (out_sum4 !== e.sum || out_cout4 !== e.cout) begin
      errors++; $display("FAIL bp_new_result: got %b_%h want %b_%h", out_cout4, out_sum4, e.cout, e.sum);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    localparam int N = 1000;
    int got4 = 0, got1 = 0;
    fork
      begin : drv4
        for (int k = 0; k < N; k++) begin
          int n = 0;
          logic [127:0] a, b;
          logic c;
          a = {$urandom, $urandom, $urandom, $urandom};
          b = {$urandom, $urandom, $urandom, $urandom};
          if ($urandom_range(0, 7) == 0) a = ONES;
          c = 1'($urandom_range(0, 1));
          in_valid4 = 1'b1; in_a4 = a; in_b4 = b; in_cin4 = c;
          while (!in_ready4 && n < 200) begin @(negedge clk); n++; end
          if (!in_ready4) begin checks++; errors++; $display("FAIL b2b4_accept_timeout: op %0d", k); break; end
          q4.push_back(model4(a, b, c));
          @(negedge clk);
        end
        in_valid4 = 1'b0;
      end
      begin : mon4
        exp4_t e;
        for (int cyc = 0; cyc < 30000 && got4 < N; cyc++) begin
          out_ready4 = ($urandom_range(0, 3) != 0);
          if (out_valid4 && out_ready4) begin
            checks++;
            if (q4.size() == 0) begin
              errors++; $display("FAIL b2b4_extra_result: got %h with empty scoreboard", out_sum4);
            end else begin
              e = q4.pop_front();
              if (out_sum4 !== e.sum || out_cout4 !== e.cout) begin
                errors++; $display("FAIL b2b4_result_%0d: got %b_%h want %b_%h", got4, out_cout4, out_sum4, e.cout, e.sum);
              end
            end
            got4++;
          end
          @(negedge clk);
        end
        out_ready4 = 1'b1;
      end
      begin : drv1
        for (int k = 0; k < N; k++) begin
          int n = 0;
          logic [31:0] a, b;
          logic c;
          a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          b = $urandom;
          c = 1'($urandom_range(0, 1));
          in_valid1 = 1'b1; in_a1 = a; in_b1 = b; in_cin1 = c;
          while (!in_ready1 && n < 200) begin @(negedge clk); n++; end
          if (!in_ready1) begin checks++; errors++; $display("FAIL b2b1_accept_timeout: op %0d", k); break; end
          q1.push_back({1'b0, a} + {1'b0, b} + {32'd0, c});
          @(negedge clk);
        end
        in_valid1 = 1'b0;
      end
      begin : mon1
        logic [32:0] e;
        for (int cyc = 0; cyc < 30000 && got1 < N; cyc++) begin
          out_ready1 = ($urandom_range(0, 3) != 0);
          if (out_valid1 && out_ready1) begin
            checks++;
            if (q1.size() == 0) begin
              errors++; $display("FAIL b2b1_extra_result: got %h with empty scoreboard", out_sum1);
            end else begin
              e = q1.pop_front();
              if ({out_cout1, out_sum1} !== e) begin
                errors++; $display("FAIL b2b1_result_%0d: got %h want %h", got1, {out_cout1, out_sum1}, e);
              end
            end
            got1++;
          end
          @(negedge clk);
        end
        out_ready1 = 1'b1;
      end
    join
    checks += 2;
    if (got4 != N || q4.size() != 0) begin
      errors++; $display("FAIL b2b4_count: got %0d results, %0d left, want %0d and 0", got4, q4.size(), N);
    end
    if (got1 != N || q1.size() != 0) begin
      errors++; $display("FAIL b2b1_count: got %0d results, %0d left, want %0d and 0", got1, q1.size(), N);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset_state();
    test_simple();
    test_ripple();
    test_max();
    test_reset_mid_run();
    test_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addn_seq.md
Name: addn_seq

Overview:
- Multi-word addition sequencer. Wraps the registered 32-bit adder `add32_cla` to add WORDS×32-bit operands.
- Accepts one wide operand pair over a valid/ready handshake and feeds the adder one 32-bit word per cycle, least significant word (LSW) first.
- Captures each registered sum and chains the adder's registered carry into the next word's carry-in.
- Presents the assembled wide result downstream over valid/ready.
- Sits directly upstream and downstream of `add32_cla`; the parent connects the adder ports.

Parameters:
- WORDS, 4, number of 32-bit words per operand; must be ≥1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low. Also drives the adder's rst.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  32*WORDS  operand A.
- in_b  in  32*WORDS  operand B.
- in_cin  in  1  carry-in into the LSW.
- add_enable  out  1  to adder enable.
- add_a  out  32  to adder a.
- add_b  out  32  to adder b.
- add_cin  out  1  to adder cin.
- add_sum  in  32  from adder sum_r; reflects the previous enabled cycle.
- add_cout  in  1  from adder cout_r.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  32*WORDS  wide sum.
- out_cout  out  1  carry-out of the most significant word (MSW).

Behaviour:
- Adder contract: when add_enable=1 at edge E, add_sum/add_cout hold {cout,sum} of (add_a+add_b+add_cin) from cycle E+1 onward. The adder holds its outputs while enable=0.
- States: IDLE, RUN, FLUSH, DONE. Word index idx has width clog2(WORDS) (min 1).
- IDLE:
  - in_ready=1 (combinational, state==IDLE only).
  - On in_valid&&in_ready: latch in_a, in_b, in_cin; idx<=0; go to RUN.
- RUN (one cycle per word k=idx):
  - add_enable=1.
  - add_a = a_lat[32k+:32]; add_b = b_lat[32k+:32].
  - add_cin = cin_lat when k==0, else add_cout (combinational pass-through of the previous word's registered carry).
  - When k>0: out_sum[32(k-1)+:32] <= add_sum.
  - If k==WORDS-1, go to FLUSH; else idx<=k+1.
- FLUSH:
  - add_enable=0.
  - out_sum[32(WORDS-1)+:32] <= add_sum; out_cout <= add_cout.
  - Go to DONE.
- DONE:
  - out_valid=1.
  - On out_ready, go to IDLE.
  - out_sum and out_cout stay stable while out_valid && !out_ready.
- Latency: accept at edge E0; add_enable is high for exactly WORDS cycles; out_valid is high from edge E0+WORDS+1.
- Throughput: one operation per WORDS+3 cycles when out_ready=1.
- add_a, add_b and add_cin are driven to 0 whenever add_enable=0.
- WORDS=1: RUN lasts one cycle with add_cin=cin_lat, then FLUSH.
- in_valid while busy: ignored (in_ready=0). Upstream must hold its data until accepted.
- Reset (rst=0 at any edge, including mid-RUN or mid-DONE):
  - State <= IDLE; in-flight operation dropped.
  - out_valid=0, out_sum=0, out_cout=0, add_enable=0, idx=0, latched operands=0.
  - in_ready=1 after the first edge with rst=1.
- Arithmetic: unsigned, modulo 2^(32*WORDS). The carry-out is exposed only on out_cout.

Decomposition:
- Package `add_pkg`:
  - WORD_W=32.
  - State enum typedef {IDLE, RUN, FLUSH, DONE}.
- No sub-module; the adder is instantiated beside the sequencer in the parent.
- The bench top instantiates `addn_seq` + `add32_cla`, sharing clk and rst.

Test Plan:
- Reset: assert rst=0 for 2 cycles while in RUN (idx=2) -> after the edge, out_valid=0, add_enable=0, out_sum=0; in_ready=1 once rst=1.
- Simple add (WORDS=4): a=128'h1, b=128'h1, cin=0 -> out_sum=128'h2, out_cout=0. add_enable high exactly 4 cycles; out_valid at accept+5.
- Full carry ripple: a=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> out_sum=0, out_cout=1. add_cin=1 on words 1..3.
- Max operands: a=b=all-ones, cin=1 -> out_sum=all-ones, out_cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out_valid stays 1, out_sum stable, in_ready=0, add_enable=0. Release out_ready -> IDLE next edge, new operand accepted.
- Random: 1000 back-to-back ops for WORDS=1 and WORDS=4 against a wide-add model -> all sums and carries match, with zero lost or duplicated results.
